// File: rtl/ahblite_cmd_master_if.sv
// Command/response handshake plus AHB-Lite manager-side bus bundle for ahblite_cmd_master.
// The master modport is the initiator's view; the slave modport is the environment's view.
interface ahblite_cmd_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
        input  rsp_ready,
        input  HRDATA, HREADY, HRESP,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
        output rsp_ready,
        output HRDATA, HREADY, HRESP,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
    );
endinterface

// File: rtl/ahblite_cmd_master.sv
// Single-outstanding AHB-Lite initiator: one command becomes one SINGLE transfer,
// with wait-state, two-cycle ERROR, misalignment and stuck-HREADY timeout handling.
module ahblite_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    ahblite_cmd_master_if.master   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [1:0]       TRANS_IDLE   = 2'b00;
    localparam logic [1:0]       TRANS_NONSEQ = 2'b10;
    localparam logic [CNT_W-1:0] TO_LIMIT     = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TO_EN        = (TIMEOUT_CYCLES != 0);

    function automatic logic cmd_rejected(input logic [2:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (size > 3'd2)
            bad = 1'b1;
        else if (size == 3'd1 && addr_lo[0] != 1'b0)
            bad = 1'b1;
        else if (size == 3'd2 && addr_lo != 2'b00)
            bad = 1'b1;
        return bad;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       htrans_q, htrans_d;
    logic [31:0]      haddr_q, haddr_d;
    logic             hwrite_q, hwrite_d;
    logic [2:0]       hsize_q, hsize_d;
    logic [31:0]      hwdata_q, hwdata_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             cmd_ready;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    logic             to_hit;

    assign cmd_ready = (state_q == S_IDLE) && !rsp_valid_q;
    assign accept    = cmd_ready && bus.cmd_valid;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    // The edge that would complete the Nth consecutive low cycle is the abort edge.
    assign to_hit    = TO_EN && (cnt_inc == TO_LIMIT);

    always_comb begin
        state_d       = state_q;
        htrans_d      = htrans_q;
        haddr_d       = haddr_q;
        hwrite_d      = hwrite_q;
        hsize_d       = hsize_q;
        hwdata_d      = hwdata_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;

        if (rsp_valid_q && bus.rsp_ready)
            rsp_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    if (cmd_rejected(bus.cmd_size, bus.cmd_addr[1:0])) begin
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = '0;
                    end else begin
                        state_d  = S_ADDR;
                        htrans_d = TRANS_NONSEQ;
                        haddr_d  = bus.cmd_addr;
                        hwrite_d = bus.cmd_write;
                        hsize_d  = bus.cmd_size;
                        wdata_d  = bus.cmd_wdata;
                    end
                end
            end

            S_ADDR: begin
                if (bus.HREADY) begin
                    state_d  = S_DATA;
                    htrans_d = TRANS_IDLE;
                    hwdata_d = wdata_q;
                    cnt_d    = '0;
                end else if (to_hit) begin
                    state_d       = S_IDLE;
                    htrans_d      = TRANS_IDLE;
                    cnt_d         = '0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_DATA: begin
                if (bus.HREADY) begin
                    // HRESP with HREADY high is the closing cycle of an ERROR response.
                    state_d       = S_IDLE;
                    cnt_d         = '0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = bus.HRESP;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!bus.HRESP && !hwrite_q) ? bus.HRDATA : 32'h0;
                end else if (to_hit) begin
                    state_d       = S_IDLE;
                    htrans_d      = TRANS_IDLE;
                    cnt_d         = '0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d  = S_IDLE;
                htrans_d = TRANS_IDLE;
                cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q       <= S_IDLE;
            htrans_q      <= TRANS_IDLE;
            haddr_q       <= '0;
            hwrite_q      <= 1'b0;
            hsize_q       <= '0;
            hwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            htrans_q      <= htrans_d;
            haddr_q       <= haddr_d;
            hwrite_q      <= hwrite_d;
            hsize_q       <= hsize_d;
            hwdata_q      <= hwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    // Write-data holding register is only meaningful after an accept, so it is not reset.
    always_ff @(posedge HCLK) begin
        wdata_q <= wdata_d;
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

    assign bus.HADDR     = haddr_q;
    assign bus.HTRANS    = htrans_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HSIZE     = hsize_q;
    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = 4'b0011;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahblite_cmd_master.sv
// Scenario bench for ahblite_cmd_master: directed bus-slave behaviour per task, responses
// checked against a queue of expected results pushed when each command is issued.
module tb_ahblite_cmd_master;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    logic HCLK;
    logic HRESET;
    int   checks;
    int   failures;
    rsp_t exp_q[$];

    ahblite_cmd_master_if bus ();

    ahblite_cmd_master #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (16)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_cmd(input logic [31:0] a, input logic w, input logic [2:0] s,
                             input logic [31:0] d);
        @(posedge HCLK); #1;
        bus.cmd_addr  = a;
        bus.cmd_write = w;
        bus.cmd_size  = s;
        bus.cmd_wdata = d;
        bus.cmd_valid = 1'b1;
        @(posedge HCLK); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        checks++;
        if (bus.HTRANS !== 2'b00 || bus.HADDR !== 32'h0 || bus.HWDATA !== 32'h0 ||
            bus.HSIZE !== 3'h0 || bus.HWRITE !== 1'b0) begin
            failures++;
            $display("FAIL reset_bus: htrans=%h haddr=%h hwdata=%h hsize=%h hwrite=%b expected all 0",
                     bus.HTRANS, bus.HADDR, bus.HWDATA, bus.HSIZE, bus.HWRITE);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_timeout !== 1'b0 ||
            bus.rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rsp: valid=%b err=%b to=%b rdata=%h expected all 0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata);
        end
        checks++;
        if (bus.HBURST !== 3'b000 || bus.HPROT !== 4'b0011 || bus.HMASTLOCK !== 1'b0) begin
            failures++;
            $display("FAIL reset_consts: hburst=%h hprot=%h hmastlock=%b expected 0/3/0",
                     bus.HBURST, bus.HPROT, bus.HMASTLOCK);
        end
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready);
        end
    endtask

    task automatic test_write_zero_wait();
        exp_q.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
        drive_cmd(32'h4000_0000, 1'b1, 3'd2, 32'h0000_00A5);
        @(negedge HCLK);
        checks++;
        if (bus.HTRANS !== 2'b10 || bus.HWRITE !== 1'b1 || bus.HADDR !== 32'h4000_0000 ||
            bus.HSIZE !== 3'd2) begin
            failures++;
            $display("FAIL wr_addr_phase: htrans=%h hwrite=%b haddr=%h hsize=%h expected 2/1/40000000/2",
                     bus.HTRANS, bus.HWRITE, bus.HADDR, bus.HSIZE);
        end
        @(negedge HCLK);
        checks++;
        if (bus.HTRANS !== 2'b00 || bus.HWDATA !== 32'h0000_00A5 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_data_phase: htrans=%h hwdata=%h rsp_valid=%b expected 0/000000a5/0",
                     bus.HTRANS, bus.HWDATA, bus.rsp_valid);
        end
        @(negedge HCLK);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL wr_latency: rsp_valid=%b cmd_ready=%b expected 1/0",
                     bus.rsp_valid, bus.cmd_ready);
        end
        @(posedge HCLK); #1;
    endtask

    task automatic test_read_wait();
        exp_q.push_back('{rdata: 32'h0001_86A0, err: 1'b0, to: 1'b0});
        drive_cmd(32'h4000_0004, 1'b0, 3'd2, 32'hDEAD_BEEF);
        bus.HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            checks++;
            if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h4000_0004 || bus.HWRITE !== 1'b0) begin
                failures++;
                $display("FAIL rd_wait_hold%0d: htrans=%h haddr=%h hwrite=%b expected 2/40000004/0",
                         i, bus.HTRANS, bus.HADDR, bus.HWRITE);
            end
            @(posedge HCLK); #1;
        end
        bus.HREADY = 1'b1;
        bus.HRDATA = 32'h0001_86A0;
        @(negedge HCLK);
        checks++;
        if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h4000_0004) begin
            failures++;
            $display("FAIL rd_wait_hold3: htrans=%h haddr=%h expected 2/40000004", bus.HTRANS, bus.HADDR);
        end
        @(negedge HCLK);
        checks++;
        if (bus.HTRANS !== 2'b00 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rd_data_phase: htrans=%h rsp_valid=%b expected 0/0", bus.HTRANS, bus.rsp_valid);
        end
        @(negedge HCLK);
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL rd_latency: rsp_valid=%b expected 1 five cycles after accept", bus.rsp_valid);
        end
        @(posedge HCLK); #1;
        bus.HRDATA = 32'h0;
    endtask

    task automatic test_error();
        exp_q.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b0});
        bus.HRDATA = 32'h1111_2222;
        drive_cmd(32'h5000_0000, 1'b1, 3'd2, 32'h1234_5678);
        @(negedge HCLK);
        checks++;
        if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h5000_0000) begin
            failures++;
            $display("FAIL err_addr_phase: htrans=%h haddr=%h expected 2/50000000", bus.HTRANS, bus.HADDR);
        end
        @(posedge HCLK); #1;
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
        @(negedge HCLK);
        checks++;
        if (bus.HTRANS !== 2'b00 || bus.rsp_valid !== 1'b0 || bus.HWDATA !== 32'h1234_5678) begin
            failures++;
            $display("FAIL err_cycle1: htrans=%h rsp_valid=%b hwdata=%h expected 0/0/12345678",
                     bus.HTRANS, bus.rsp_valid, bus.HWDATA);
        end
        @(posedge HCLK); #1;
        bus.HREADY = 1'b1;
        @(negedge HCLK);
        checks++;
        if (bus.HTRANS !== 2'b00 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL err_cycle2: htrans=%h rsp_valid=%b expected 0/0", bus.HTRANS, bus.rsp_valid);
        end
        @(posedge HCLK); #1;
        bus.HRESP = 1'b0;
        @(negedge HCLK);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_timeout !== 1'b0) begin
            failures++;
            $display("FAIL err_rsp: valid=%b err=%b to=%b expected 1/1/0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_timeout);
        end
        @(posedge HCLK); #1;
        bus.HRDATA = 32'h0;
    endtask

    task automatic test_reject();
        logic [31:0] addrs [3];
        logic [2:0]  sizes [3];
        addrs[0] = 32'h4000_0002; sizes[0] = 3'd2;
        addrs[1] = 32'h4000_0000; sizes[1] = 3'd3;
        addrs[2] = 32'h4000_0001; sizes[2] = 3'd1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b0});
            drive_cmd(addrs[i], 1'b1, sizes[i], 32'hFFFF_FFFF);
            @(negedge HCLK);
            checks++;
            if (bus.HTRANS !== 2'b00 || bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1) begin
                failures++;
                $display("FAIL reject%0d: htrans=%h rsp_valid=%b rsp_err=%b expected 0/1/1",
                         i, bus.HTRANS, bus.rsp_valid, bus.rsp_err);
            end
            @(negedge HCLK);
            checks++;
            if (bus.HTRANS !== 2'b00 || bus.rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL reject%0d_quiet: htrans=%h rsp_valid=%b expected 0/0",
                         i, bus.HTRANS, bus.rsp_valid);
            end
        end
    endtask

    task automatic test_timeout();
        exp_q.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b1});
        drive_cmd(32'h4000_0010, 1'b1, 3'd2, 32'h0BAD_0BAD);
        bus.HREADY = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge HCLK);
            checks++;
            if (bus.HTRANS !== 2'b10 || bus.rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL timeout_low%0d: htrans=%h rsp_valid=%b expected 2/0",
                         k, bus.HTRANS, bus.rsp_valid);
            end
            @(posedge HCLK); #1;
        end
        @(negedge HCLK);
        checks++;
        if (bus.HTRANS !== 2'b00 || bus.rsp_valid !== 1'b1 || bus.rsp_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_abort: htrans=%h rsp_valid=%b rsp_timeout=%b expected 0/1/1",
                     bus.HTRANS, bus.rsp_valid, bus.rsp_timeout);
        end
        @(posedge HCLK); #1;
        bus.HREADY = 1'b1;
        bus.HRDATA = 32'hCAFE_F00D;
        exp_q.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0, to: 1'b0});
        drive_cmd(32'h4000_0008, 1'b0, 3'd2, 32'h0);
        @(negedge HCLK);
        checks++;
        if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h4000_0008) begin
            failures++;
            $display("FAIL timeout_recover: htrans=%h haddr=%h expected 2/40000008", bus.HTRANS, bus.HADDR);
        end
        @(negedge HCLK);
        @(negedge HCLK);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_recover_rsp: valid=%b to=%b expected 1/0", bus.rsp_valid, bus.rsp_timeout);
        end
        @(posedge HCLK); #1;
        bus.HRDATA = 32'h0;
    endtask

    task automatic test_reset_mid();
        bus.HRDATA = 32'h7777_7777;
        drive_cmd(32'h4000_0020, 1'b0, 3'd2, 32'h0);
        @(negedge HCLK);
        @(posedge HCLK); #1;
        bus.HREADY = 1'b0;
        HRESET     = 1'b1;
        @(posedge HCLK); #1;
        HRESET     = 1'b0;
        bus.HREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            checks++;
            if (bus.HTRANS !== 2'b00 || bus.rsp_valid !== 1'b0 || bus.HADDR !== 32'h0 ||
                bus.cmd_ready !== 1'b1) begin
                failures++;
                $display("FAIL reset_mid%0d: htrans=%h rsp_valid=%b haddr=%h cmd_ready=%b expected 0/0/0/1",
                         i, bus.HTRANS, bus.rsp_valid, bus.HADDR, bus.cmd_ready);
            end
        end
        bus.HRDATA = 32'h0;
    endtask

    task automatic test_rsp_stall();
        logic [31:0] rdata0;
        logic        err0;
        bus.rsp_ready = 1'b0;
        bus.HRDATA    = 32'h5A5A_5A5A;
        exp_q.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
        drive_cmd(32'h4000_0030, 1'b1, 3'd2, 32'h0000_55AA);
        @(negedge HCLK);
        @(negedge HCLK);
        @(negedge HCLK);
        rdata0 = bus.rsp_rdata;
        err0   = bus.rsp_err;
        checks++;
        if (bus.rsp_valid !== 1'b1 || rdata0 !== 32'h0 || err0 !== 1'b0) begin
            failures++;
            $display("FAIL stall_rsp: valid=%b rdata=%h err=%b expected 1/0/0", bus.rsp_valid, rdata0, err0);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge HCLK); #1;
            bus.cmd_addr  = 32'h4000_0040;
            bus.cmd_write = 1'b1;
            bus.cmd_size  = 3'd2;
            bus.cmd_valid = 1'b1;
            @(negedge HCLK);
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== rdata0 || bus.rsp_err !== err0 ||
                bus.cmd_ready !== 1'b0 || bus.HTRANS !== 2'b00) begin
                failures++;
                $display("FAIL stall_hold%0d: valid=%b rdata=%h err=%b cmd_ready=%b htrans=%h expected 1/%h/%b/0/0",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.cmd_ready, bus.HTRANS, rdata0, err0);
            end
        end
        @(posedge HCLK); #1;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge HCLK); #1;
        @(negedge HCLK);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.HTRANS !== 2'b00) begin
            failures++;
            $display("FAIL stall_release: valid=%b cmd_ready=%b htrans=%h expected 0/1/0",
                     bus.rsp_valid, bus.cmd_ready, bus.HTRANS);
        end
        bus.HRDATA = 32'h0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        HRESET        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_write = 1'b0;
        bus.cmd_size  = 3'd0;
        bus.cmd_wdata = 32'h0;
        bus.rsp_ready = 1'b1;
        bus.HRDATA    = 32'h0;
        bus.HREADY    = 1'b1;
        bus.HRESP     = 1'b0;

        fork
            forever begin
                @(negedge HCLK);
                if (!HRESET && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL sb_unexpected: rdata=%h err=%b to=%b with no response expected",
                                 bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout);
                    end else begin
                        rsp_t e;
                        e = exp_q.pop_front();
                        if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err ||
                            bus.rsp_timeout !== e.to) begin
                            failures++;
                            $display("FAIL sb_rsp: rdata=%h err=%b to=%b expected rdata=%h err=%b to=%b",
                                     bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout, e.rdata, e.err, e.to);
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_error();
        test_reject();
        test_timeout();
        test_reset_mid();
        test_rsp_stall();

        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_missing: %0d responses outstanding, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
